// File: rtl/c_drain_fsm_pkg.sv
// rtl/c_drain_fsm_pkg.sv - shared types and width helpers for the C-drain controller
package c_drain_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } drain_state_e;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Array pipeline depth from A/B entry to the last C update.
  function automatic int flush_cycles(input int ml);
    return 2 * ml - 1;
  endfunction

endpackage

// File: rtl/c_drain_fsm_if.sv
// rtl/c_drain_fsm_if.sv - valid/ready row stream from the C drain to writeback
interface c_drain_fsm_if #(
  parameter int ml = 2,
  parameter int dw = 16
);
  localparam int row_w = c_drain_fsm_pkg::cnt_w(ml);

  logic                 out_valid;
  logic                 out_ready;
  logic [ml*dw-1:0]     out_data;
  logic [row_w-1:0]     out_row;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    output out_ready
  );

endinterface

// File: rtl/c_drain_fsm.sv
// rtl/c_drain_fsm.sv - waits out the array pipeline, then shifts C rows onto a valid/ready stream
module c_drain_fsm
  import c_drain_fsm_pkg::*;
#(
  parameter int ml = 2,
  parameter int dw = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             drain_req,
  input  logic             ab_valid,
  input  logic [ml*dw-1:0] c_row_in,
  output logic             en_shift,
  output logic             busy,
  output logic             done,
  c_drain_fsm_if.master    out_if
);

  localparam int FLUSH_CYCLES = flush_cycles(ml);
  localparam int FW           = cnt_w(FLUSH_CYCLES);
  localparam int RW           = cnt_w(ml);

  drain_state_e     state, state_nx;
  logic [FW-1:0]    flush_cnt;
  logic [RW-1:0]    row_cnt;
  logic             out_valid_q;
  logic [ml*dw-1:0] out_data_q;
  logic [RW-1:0]    out_row_q;
  logic             done_q;

  logic             load;
  logic             flush_clr;
  logic             flush_inc;
  logic             row_clr;
  logic             fin;
  logic             flush_last;
  logic             row_last;

  assign flush_last = (flush_cnt == FW'(FLUSH_CYCLES - 1));
  assign row_last   = (row_cnt == RW'(ml - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    en_shift  = 1'b0;
    flush_clr = 1'b0;
    flush_inc = 1'b0;
    row_clr   = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (drain_req) begin
          state_nx  = ST_FLUSH;
          flush_clr = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Any A/B activity means C is still being updated: restart the wait.
        if (ab_valid) begin
          flush_clr = 1'b1;
        end else if (flush_last) begin
          state_nx = ST_SHIFT;
          row_clr  = 1'b1;
        end else begin
          flush_inc = 1'b1;
        end
      end
      ST_SHIFT: begin
        load     = !out_valid_q || out_if.out_ready;
        en_shift = load;
        if (load && row_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_valid_q && out_if.out_ready) begin
          state_nx = ST_IDLE;
          fin      = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      if (flush_clr)      flush_cnt <= '0;
      else if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      if (row_clr)        row_cnt   <= '0;
      else if (load)      row_cnt   <= row_cnt + 1'b1;
    end
  end

  // One-entry output stage: the row is captured in the same cycle the column shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= c_row_in;
        out_row_q   <= row_cnt;
      end else if (out_valid_q && out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      done_q <= fin;
    end
  end

  assign busy             = (state != ST_IDLE);
  assign done             = done_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_row   = out_row_q;

endmodule

// File: tb/tb_c_drain_fsm.sv
// tb/tb_c_drain_fsm.sv - directed checks of c_drain_fsm at ml=2 and ml=4
module tb_c_drain_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req2, abv2, en2, busy2, done2;
  logic [31:0] crow2;
  c_drain_fsm_if #(.ml(2), .dw(16)) if2();
  c_drain_fsm #(.ml(2), .dw(16)) u2 (
    .clk(clk), .reset(reset), .drain_req(req2), .ab_valid(abv2), .c_row_in(crow2),
    .en_shift(en2), .busy(busy2), .done(done2), .out_if(if2)
  );

  logic        req4, abv4, en4, busy4, done4;
  logic [63:0] crow4;
  c_drain_fsm_if #(.ml(4), .dw(16)) if4();
  c_drain_fsm #(.ml(4), .dw(16)) u4 (
    .clk(clk), .reset(reset), .drain_req(req4), .ab_valid(abv4), .c_row_in(crow4),
    .en_shift(en4), .busy(busy4), .done(done4), .out_if(if4)
  );

  logic [31:0] rows2 [4] = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
  logic [63:0] rows4 [4] = '{64'h1111_0001_0002_0003, 64'h2222_0004_0005_0006,
                             64'h3333_0007_0008_0009, 64'h4444_000a_000b_000c};

  // Array bottom row model: advances one row per en_shift.
  logic [1:0] sidx2, sidx4;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sidx2 <= 2'd0;
      sidx4 <= 2'd0;
    end else begin
      if (en2) sidx2 <= sidx2 + 2'd1;
      if (en4) sidx4 <= sidx4 + 2'd1;
    end
  end
  assign crow2 = rows2[sidx2];
  assign crow4 = rows4[sidx4];

  int checks   = 0;
  int failures = 0;
  int beat2, dones2, beat4, dones4;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req2 = 1'b0; abv2 = 1'b0; if2.out_ready = 1'b0;
    req4 = 1'b0; abv4 = 1'b0; if4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    beat2 = 0; dones2 = 0; beat4 = 0; dones4 = 0;
  endtask

  // Bit c of each mask is the stimulus or expectation for cycle c.
  task automatic run_vec(input string name, input int n,
                         input logic [15:0] req, input logic [15:0] rdy, input logic [15:0] abv,
                         input logic [15:0] en_m, input logic [15:0] ov_m,
                         input logic [15:0] done_m, input logic [15:0] busy_m);
    for (int c = 0; c < n; c++) begin
      req2 = req[c];
      if2.out_ready = rdy[c];
      abv2 = abv[c];
      @(negedge clk);
      check_eq($sformatf("%s c%0d en_shift", name, c), 64'(en2), 64'(en_m[c]));
      check_eq($sformatf("%s c%0d out_valid", name, c), 64'(if2.out_valid), 64'(ov_m[c]));
      check_eq($sformatf("%s c%0d done", name, c), 64'(done2), 64'(done_m[c]));
      check_eq($sformatf("%s c%0d busy", name, c), 64'(busy2), 64'(busy_m[c]));
      if (if2.out_valid) begin
        check_eq($sformatf("%s c%0d out_data", name, c), 64'(if2.out_data), 64'(rows2[beat2[1:0]]));
        check_eq($sformatf("%s c%0d out_row", name, c), 64'(if2.out_row), 64'(beat2));
        if (if2.out_ready) beat2++;
      end
      if (done2) dones2++;
      @(posedge clk);
      #1;
    end
    req2 = 1'b0;
    abv2 = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check_eq("reset busy", 64'(busy2), 64'd0);
    check_eq("reset out_valid", 64'(if2.out_valid), 64'd0);
    check_eq("reset done", 64'(done2), 64'd0);
    check_eq("reset out_data", 64'(if2.out_data), 64'd0);
    @(posedge clk);
    #1;

    // Basic latency, continuous ready.
    do_reset();
    run_vec("basic", 10, 16'h0001, 16'hFFFF, 16'h0000, 16'h0030, 16'h0060, 16'h0080, 16'h007E);
    check_eq("basic beats", 64'(beat2), 64'd2);
    check_eq("basic dones", 64'(dones2), 64'd1);

    // Backpressure cycles 5-7.
    do_reset();
    run_vec("bp", 12, 16'h0001, 16'hFF1F, 16'h0000, 16'h0110, 16'h03E0, 16'h0400, 16'h03FE);
    check_eq("bp beats", 64'(beat2), 64'd2);

    // ab_valid during flush restarts the wait.
    do_reset();
    run_vec("abv", 12, 16'h0001, 16'hFFFF, 16'h0004, 16'h00C0, 16'h0180, 16'h0200, 16'h01FE);
    check_eq("abv dones", 64'(dones2), 64'd1);

    // Second drain_req while busy is ignored.
    do_reset();
    run_vec("rereq", 14, 16'h0021, 16'hFFFF, 16'h0000, 16'h0030, 16'h0060, 16'h0080, 16'h007E);
    check_eq("rereq beats", 64'(beat2), 64'd2);
    check_eq("rereq dones", 64'(dones2), 64'd1);

    // Asynchronous reset mid-cycle while a row is valid.
    do_reset();
    run_vec("pre_rst", 5, 16'h0001, 16'hFFFF, 16'h0000, 16'h0030, 16'h0020, 16'h0000, 16'h001E);
    #2 reset = 1'b1;
    #1;
    check_eq("async out_valid", 64'(if2.out_valid), 64'd0);
    check_eq("async busy", 64'(busy2), 64'd0);
    check_eq("async en_shift", 64'(en2), 64'd0);
    check_eq("async done", 64'(done2), 64'd0);
    check_eq("async out_data", 64'(if2.out_data), 64'd0);
    check_eq("async out_row", 64'(if2.out_row), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    beat2 = 0; dones2 = 0;
    run_vec("post_rst", 10, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check_eq("post_rst dones", 64'(dones2), 64'd0);

    // ml=4 with toggling ready.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      req4 = (c == 0);
      if4.out_ready = (c % 2 == 0);
      @(negedge clk);
      if (if4.out_valid) begin
        check_eq($sformatf("ml4 c%0d out_data", c), if4.out_data, rows4[beat4[1:0]]);
        check_eq($sformatf("ml4 c%0d out_row", c), 64'(if4.out_row), 64'(beat4));
        if (if4.out_ready) beat4++;
      end
      if (done4) begin
        dones4++;
        check_eq($sformatf("ml4 c%0d beats at done", c), 64'(beat4), 64'd4);
      end
      @(posedge clk);
      #1;
    end
    req4 = 1'b0;
    check_eq("ml4 beats", 64'(beat4), 64'd4);
    check_eq("ml4 dones", 64'(dones4), 64'd1);
    check_eq("ml4 idle", 64'(busy4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
